// File: rtl/bias_add_stage.sv
// Adds one bias word per output-channel group, lane-wise, to NPE result beats, with optional saturation and ReLU.
// Latency: 1 cycle from an NPE transfer (vld & rdy) to o_dat_vld; one bias fetch (FETCH + WAIT) per group.
// Backpressure: o_npe_rdy is high only in RUN, and drops for at least 2 cycles between groups while the next bias word is fetched.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_calc_en                start pulse (latches config, ignored while busy)
//   i_calculate_end          abort, returns to IDLE on the next cycle
//   i_addr_start_b           bias RAM address of group 0
//   i_part_num               beats per group (0 means 1)
//   i_output_layers          number of groups (0 means 1)
//   i_relu_en, i_sat_en      post-add ReLU / saturation enables
//   i_npe_dat/_vld, o_npe_rdy  NPE beat input handshake
//   o_ram_addr, o_ram_rd_en, i_ram_dat, i_ram_dat_vld  bias RAM read port
//   o_dat, o_dat_vld         registered biased result
//   o_busy, o_done           FSM not idle / end-of-run pulse
module bias_add_stage #(
    parameter int LANES  = 32,
    parameter int DW     = 16,
    parameter int ADDR_W = 8,
    parameter int PART_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_calc_en,
    input  logic                  i_calculate_end,
    input  logic [ADDR_W-1:0]     i_addr_start_b,
    input  logic [PART_W-1:0]     i_part_num,
    input  logic [7:0]            i_output_layers,
    input  logic                  i_relu_en,
    input  logic                  i_sat_en,
    input  logic [LANES*DW-1:0]   i_npe_dat,
    input  logic                  i_npe_dat_vld,
    output logic                  o_npe_rdy,
    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic                  o_ram_rd_en,
    input  logic [LANES*DW-1:0]   i_ram_dat,
    input  logic                  i_ram_dat_vld,
    output logic [LANES*DW-1:0]   o_dat,
    output logic                  o_dat_vld,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [ADDR_W-1:0]    start_q;
    logic [PART_W-1:0]    part_q;
    logic [PART_W-1:0]    p_q;
    logic [7:0]           layers_q;
    logic [7:0]           g_q;
    logic                 relu_q;
    logic                 sat_q;
    logic [LANES*DW-1:0]  bias_q;
    logic [LANES*DW-1:0]  res;
    logic                 xfer;
    logic                 last_part;
    logic                 last_group;

    assign xfer       = i_npe_dat_vld && o_npe_rdy;
    // part_q / layers_q are stored already forced to at least 1, so these compares never underflow.
    assign last_part  = (p_q == part_q - PART_W'(1));
    assign last_group = (g_q == layers_q - 8'd1);

    assign o_npe_rdy   = (state == S_RUN);
    assign o_ram_rd_en = (state == S_FETCH);
    assign o_busy      = (state != S_IDLE);
    // Address arithmetic wraps naturally at ADDR_W bits.
    assign o_ram_addr  = start_q + ADDR_W'(g_q);

    // Per-lane add in DW+1 bits, then optional saturation and ReLU.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DW:0]   sum;
        logic [DW-1:0] sat_v;
        logic [DW-1:0] npe_l;
        logic [DW-1:0] bias_l;

        assign npe_l  = i_npe_dat[i*DW +: DW];
        assign bias_l = bias_q[i*DW +: DW];
        assign sum    = {npe_l[DW-1], npe_l} + {bias_l[DW-1], bias_l};

        always_comb begin
            sat_v = sum[DW-1:0];
            // Overflow shows up as the two top bits disagreeing; the extra top bit is the true sign.
            if (sat_q && (sum[DW] != sum[DW-1])) begin
                sat_v = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            end
        end

        assign res[i*DW +: DW] = (relu_q && sat_v[DW-1]) ? '0 : sat_v;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_calc_en) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  if (i_ram_dat_vld) state_nxt = S_RUN;
            S_RUN:   if (xfer && last_part) state_nxt = last_group ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Abort wins over everything, including a simultaneous start.
        if (i_calculate_end) state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            start_q   <= '0;
            part_q    <= '0;
            layers_q  <= '0;
            relu_q    <= 1'b0;
            sat_q     <= 1'b0;
            p_q       <= '0;
            g_q       <= '0;
            bias_q    <= '0;
            o_dat     <= '0;
            o_dat_vld <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_dat_vld <= 1'b0;
            o_done    <= 1'b0;
            if (i_calculate_end) begin
                // A beat accepted in the abort cycle is dropped: o_dat_vld stays low.
                p_q <= '0;
                g_q <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_calc_en) begin
                            start_q  <= i_addr_start_b;
                            part_q   <= (i_part_num == '0) ? PART_W'(1) : i_part_num;
                            layers_q <= (i_output_layers == 8'd0) ? 8'd1 : i_output_layers;
                            relu_q   <= i_relu_en;
                            sat_q    <= i_sat_en;
                            p_q      <= '0;
                            g_q      <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (i_ram_dat_vld) bias_q <= i_ram_dat;
                    end
                    S_RUN: begin
                        if (xfer) begin
                            o_dat     <= res;
                            o_dat_vld <= 1'b1;
                            if (last_part) begin
                                p_q <= '0;
                                if (last_group) o_done <= 1'b1;
                                else            g_q    <= g_q + 8'd1;
                            end else begin
                                p_q <= p_q + PART_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bias_add_stage.sv
// Scoreboard bench for bias_add_stage: expected beats are queued as each NPE beat is handed over and checked as results emerge.
// Latency: results are compared on the falling edge of the cycle in which o_dat_vld is high.
// Backpressure: the NPE driver holds vld/data until it sees o_npe_rdy, optionally inserting random idle gaps.
module tb_bias_add_stage;

    localparam int LANES  = 32;
    localparam int DW     = 16;
    localparam int ADDR_W = 8;
    localparam int PART_W = 5;
    localparam int W      = LANES * DW;

    logic                i_clk;
    logic                i_rst_n;
    logic                i_calc_en;
    logic                i_calculate_end;
    logic [ADDR_W-1:0]   i_addr_start_b;
    logic [PART_W-1:0]   i_part_num;
    logic [7:0]          i_output_layers;
    logic                i_relu_en;
    logic                i_sat_en;
    logic [W-1:0]        i_npe_dat;
    logic                i_npe_dat_vld;
    logic                o_npe_rdy;
    logic [ADDR_W-1:0]   o_ram_addr;
    logic                o_ram_rd_en;
    logic [W-1:0]        i_ram_dat;
    logic                i_ram_dat_vld;
    logic [W-1:0]        o_dat;
    logic                o_dat_vld;
    logic                o_busy;
    logic                o_done;

    bias_add_stage #(.LANES(LANES), .DW(DW), .ADDR_W(ADDR_W), .PART_W(PART_W)) u_dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_calc_en       (i_calc_en),
        .i_calculate_end (i_calculate_end),
        .i_addr_start_b  (i_addr_start_b),
        .i_part_num      (i_part_num),
        .i_output_layers (i_output_layers),
        .i_relu_en       (i_relu_en),
        .i_sat_en        (i_sat_en),
        .i_npe_dat       (i_npe_dat),
        .i_npe_dat_vld   (i_npe_dat_vld),
        .o_npe_rdy       (o_npe_rdy),
        .o_ram_addr      (o_ram_addr),
        .o_ram_rd_en     (o_ram_rd_en),
        .i_ram_dat       (i_ram_dat),
        .i_ram_dat_vld   (i_ram_dat_vld),
        .o_dat           (o_dat),
        .o_dat_vld       (o_dat_vld),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           out_cnt  = 0;
    int           done_cnt = 0;
    int           ram_lat  = 1;
    logic [W-1:0] bias_mem [256];
    logic [W-1:0] exp_q [$];
    int           addr_q [$];
    logic [W-1:0] last_out;

    int cfg_start, cfg_part, cfg_layers, cfg_k, out0, done0;
    logic cfg_relu, cfg_sat;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] splat(input int v);
        logic [W-1:0] r;
        logic [31:0]  t;
        t = v;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = t[DW-1:0];
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        logic [31:0]  t;
        for (int i = 0; i < LANES; i++) begin
            t = $urandom;
            r[i*DW +: DW] = t[DW-1:0];
        end
        return r;
    endfunction

    // Reference: integer add, then clamp or wrap, then ReLU.
    function automatic logic [W-1:0] model(input logic [W-1:0] npe, input logic [W-1:0] bias,
                                           input logic sat, input logic relu);
        logic [W-1:0]  r;
        logic [DW-1:0] la, lb, t;
        int            a, b, s;
        int            maxv, minv;
        maxv = (1 << (DW - 1)) - 1;
        minv = -(1 << (DW - 1));
        for (int i = 0; i < LANES; i++) begin
            la = npe[i*DW +: DW];
            lb = bias[i*DW +: DW];
            a  = $signed(la);
            b  = $signed(lb);
            s  = a + b;
            if (sat) begin
                if (s > maxv) s = maxv;
                if (s < minv) s = minv;
            end else begin
                t = s[DW-1:0];
                s = $signed(t);
            end
            if (relu && s < 0) s = 0;
            r[i*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    // Bias RAM model: answers each read strobe after ram_lat cycles with a one-cycle valid.
    initial begin
        int a;
        i_ram_dat     = '0;
        i_ram_dat_vld = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if (i_rst_n && o_ram_rd_en) begin
                a = int'(o_ram_addr);
                addr_q.push_back(a);
                repeat (ram_lat) @(posedge i_clk);
                #1;
                i_ram_dat     = bias_mem[a];
                i_ram_dat_vld = 1'b1;
                @(posedge i_clk);
                #1;
                i_ram_dat_vld = 1'b0;
            end
        end
    end

    // Output monitor / scoreboard consumer.
    always @(negedge i_clk) begin
        logic [W-1:0] e;
        if (i_rst_n) begin
            if (o_ram_rd_en) check("rdy_low_in_fetch", o_npe_rdy, 0);
            if (o_dat_vld) begin
                check("exp_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("dat", o_dat, e);
                end
                out_cnt++;
                last_out = o_dat;
            end
            if (o_done) begin
                done_cnt++;
                check("done_with_vld", o_dat_vld, 1);
                check("done_on_last_beat", exp_q.size(), 0);
            end
        end
    end

    task automatic start_job(input int start, input int part, input int layers,
                             input logic relu, input logic sat);
        cfg_start  = start & 255;
        cfg_part   = (part == 0) ? 1 : part;
        cfg_layers = (layers == 0) ? 1 : layers;
        cfg_relu   = relu;
        cfg_sat    = sat;
        cfg_k      = 0;
        out0       = out_cnt;
        done0      = done_cnt;
        addr_q.delete();
        i_addr_start_b  = start[ADDR_W-1:0];
        i_part_num      = part[PART_W-1:0];
        i_output_layers = layers[7:0];
        i_relu_en       = relu;
        i_sat_en        = sat;
        i_calc_en       = 1'b1;
        @(posedge i_clk);
        #1;
        i_calc_en = 1'b0;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input int gap);
        int ok;
        int grp;
        if (gap > 0) begin
            i_npe_dat_vld = 1'b0;
            repeat (gap) @(posedge i_clk);
            #1;
        end
        i_npe_dat     = d;
        i_npe_dat_vld = 1'b1;
        ok = 0;
        for (int c = 0; c < 200 && ok == 0; c++) begin
            @(negedge i_clk);
            if (o_npe_rdy) begin
                grp = cfg_k / cfg_part;
                exp_q.push_back(model(d, bias_mem[(cfg_start + grp) & 255], cfg_sat, cfg_relu));
                ok = 1;
            end
        end
        check("beat_xfer", ok, 1);
        if (ok != 0) begin
            @(posedge i_clk);
            #1;
        end
        cfg_k++;
    endtask

    task automatic finish_job();
        i_npe_dat_vld = 1'b0;
        for (int c = 0; c < 20 && done_cnt == done0; c++) begin
            @(posedge i_clk);
            #1;
        end
        check("done_pulses", done_cnt - done0, 1);
        check("out_count", out_cnt - out0, cfg_part * cfg_layers);
        check("exp_drained", exp_q.size(), 0);
        check("idle_after_done", o_busy, 0);
        check("read_count", addr_q.size(), cfg_layers);
        for (int i = 0; i < addr_q.size(); i++) check("read_addr", addr_q[i], (cfg_start + i) & 255);
    endtask

    task automatic run_job(input int start, input int part, input int layers, input logic relu,
                           input logic sat, input int maxgap, input int all100);
        int pe, le;
        pe = (part == 0) ? 1 : part;
        le = (layers == 0) ? 1 : layers;
        start_job(start, part, layers, relu, sat);
        for (int k = 0; k < pe * le; k++)
            send_beat(all100 != 0 ? splat(100) : rand_word(), (maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
        finish_job();
    endtask

    initial begin
        logic [W-1:0] npe, bias;
        logic [15:0]  lane;
        i_rst_n         = 1'b0;
        i_calc_en       = 1'b0;
        i_calculate_end = 1'b0;
        i_addr_start_b  = '0;
        i_part_num      = '0;
        i_output_layers = '0;
        i_relu_en       = 1'b0;
        i_sat_en        = 1'b0;
        i_npe_dat       = '0;
        i_npe_dat_vld   = 1'b0;
        last_out        = '0;
        for (int i = 0; i < 256; i++) bias_mem[i] = '0;

        #12;
        check("rst_dat", o_dat, 0);
        check("rst_dat_vld", o_dat_vld, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_rdy", o_npe_rdy, 0);
        check("rst_rd_en", o_ram_rd_en, 0);
        check("rst_addr", o_ram_addr, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Basic run: bias 10*g at 0x10.., beats of 100.
        for (int g = 0; g < 3; g++) bias_mem[8'h10 + g] = splat(10 * g);
        run_job(8'h10, 2, 3, 1'b0, 1'b1, 0, 1);
        check("basic_last", last_out, splat(120));

        // Saturation, both modes.
        bias = rand_word();
        npe  = rand_word();
        bias[15:0] = 16'h0020; bias[31:16] = 16'hFFF0;
        npe[15:0]  = 16'h7FF0; npe[31:16]  = 16'h8005;
        bias_mem[8'h20] = bias;
        for (int s = 1; s >= 0; s--) begin
            start_job(8'h20, 1, 1, 1'b0, s[0]);
            send_beat(npe, 0);
            finish_job();
            lane = last_out[15:0];
            check("sat_lane0", lane, s[0] ? 16'h7FFF : 16'h8010);
            lane = last_out[31:16];
            check("sat_lane1", lane, s[0] ? 16'h8000 : 16'h7FF5);
        end

        // ReLU, both modes; lane 1 stays positive.
        bias_mem[8'h30] = splat(20);
        npe = splat(1000);
        npe[15:0] = 16'hFFCE;
        for (int r = 1; r >= 0; r--) begin
            start_job(8'h30, 1, 1, r[0], 1'b1);
            send_beat(npe, 0);
            finish_job();
            lane = last_out[15:0];
            check("relu_lane0", lane, r[0] ? 16'h0000 : 16'hFFE2);
            lane = last_out[31:16];
            check("relu_lane1", lane, 16'd1020);
        end

        // Continuous valid with a slow RAM, then random valid gaps.
        for (int i = 0; i < 256; i++) bias_mem[i] = rand_word();
        ram_lat = 3;
        run_job(8'h40, 3, 4, 1'b0, 1'b1, 0, 0);
        ram_lat = 2;
        run_job(8'h80, 4, 3, 1'b1, 1'b0, 2, 0);
        ram_lat = 1;

        // Address wrap with an abort during group 2.
        start_job(8'hFE, 1, 4, 1'b0, 1'b1);
        send_beat(rand_word(), 0);
        send_beat(rand_word(), 1);
        i_npe_dat_vld = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 50 && seen == 0; c++) begin
                @(negedge i_clk);
                if (o_npe_rdy) seen = 1;
            end
            check("abort_reach_run", seen, 1);
        end
        i_npe_dat       = rand_word();
        i_npe_dat_vld   = 1'b1;
        i_calculate_end = 1'b1;
        @(posedge i_clk);
        #1;
        i_npe_dat_vld   = 1'b0;
        i_calculate_end = 1'b0;
        check("abort_no_vld", o_dat_vld, 0);
        check("abort_no_done", o_done, 0);
        check("abort_busy", o_busy, 0);
        check("abort_reads", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            check("wrap_addr0", addr_q[0], 8'hFE);
            check("wrap_addr1", addr_q[1], 8'hFF);
            check("wrap_addr2", addr_q[2], 8'h00);
        end
        repeat (4) @(posedge i_clk);
        #1;
        check("abort_done_cnt", done_cnt - done0, 0);
        check("abort_out_cnt", out_cnt - out0, 2);
        run_job(8'hFE, 1, 4, 1'b0, 1'b1, 0, 0);

        // Zero config: one read, one output.
        run_job(8'h55, 0, 0, 1'b0, 1'b1, 0, 0);

        // Async reset in the middle of RUN.
        start_job(8'h60, 4, 2, 1'b0, 1'b1);
        send_beat(rand_word(), 0);
        send_beat(rand_word(), 0);
        check("pre_reset_vld", o_dat_vld, 1);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("arst_dat", o_dat, 0);
        check("arst_dat_vld", o_dat_vld, 0);
        check("arst_busy", o_busy, 0);
        check("arst_rdy", o_npe_rdy, 0);
        check("arst_done", o_done, 0);
        check("arst_rd_en", o_ram_rd_en, 0);
        i_npe_dat_vld = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        run_job(8'h70, 2, 2, 1'b0, 1'b1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bias_add_stage.md
Name: bias_add_stage

Overview:
- Parametrised bias-add stage placed after the NPE array.
- For each output-channel group it fetches one bias word from bias RAM and adds it lane-wise to the NPE result beats of that group.
- Optional saturation and ReLU are applied, and results are emitted with a valid strobe.
- Generalises the fixed 32x16b bias adder with configurable lane count and width, a ready handshake toward the NPE, and explicit done/abort behaviour.

Parameters:
- LANES, 32, number of parallel lanes per beat.
- DW, 16, signed data width per lane (NPE data and bias alike).
- ADDR_W, 8, bias RAM address width.
- PART_W, 5, width of the beats-per-group count.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_calc_en  in  1  start pulse. Latches the config and begins a run; ignored while busy.
- i_calculate_end  in  1  abort. Returns to IDLE on the next cycle.
- i_addr_start_b  in  ADDR_W  bias RAM address of group 0.
- i_part_num  in  PART_W  NPE beats per group (0 treated as 1).
- i_output_layers  in  8  number of groups (0 treated as 1).
- i_relu_en  in  1  clamp negative results to 0.
- i_sat_en  in  1  1 = saturate, 0 = two's-complement wrap.
- i_npe_dat  in  LANES*DW  NPE beat; lane i is at [i*DW +: DW].
- i_npe_dat_vld  in  1  NPE beat valid.
- o_npe_rdy  out  1  stage accepts a beat. A transfer occurs when vld & rdy.
- o_ram_addr  out  ADDR_W  bias RAM read address.
- o_ram_rd_en  out  1  one-cycle read strobe.
- i_ram_dat  in  LANES*DW  bias word, same lane packing as the NPE beat.
- i_ram_dat_vld  in  1  bias word valid.
- o_dat  out  LANES*DW  biased result.
- o_dat_vld  out  1  result valid.
- o_busy  out  1  high whenever the FSM is not IDLE.
- o_done  out  1  one-cycle pulse marking the end of a normal run.

Behaviour:
- **Reset:** all outputs 0, FSM in IDLE, counters and bias register 0.
- **Config latch:** on i_calc_en in IDLE, latch start address, part_num, output_layers, relu_en and sat_en; clear group counter g and part counter p.
- **IDLE:** o_npe_rdy = 0. Go to FETCH on i_calc_en.
- **FETCH (1 cycle):**
  - o_ram_rd_en = 1 and o_ram_addr = (start + g) mod 2^ADDR_W; address wraps with no error.
  - Go to WAIT.
- **WAIT:**
  - Hold until i_ram_dat_vld, then register i_ram_dat into the bias register and go to RUN.
  - i_ram_dat_vld received in any other state is ignored.
- **RUN:**
  - o_npe_rdy = 1.
  - On each transfer, compute per lane sum = sign-extended npe + sign-extended bias, in DW+1 bits.
  - If sat_en: results above 2^(DW-1)-1 clamp to that value; results below -2^(DW-1) clamp to -2^(DW-1). Otherwise keep the low DW bits.
  - Then, if relu_en, any negative lane becomes 0.
  - p increments per transfer.
  - On the transfer where p = part_num-1: p clears. If g = layers-1, go to DONE; else g increments and the FSM goes to FETCH.
- **Output timing:**
  - o_dat and o_dat_vld are registered, so latency is 1 cycle from transfer to o_dat_vld.
  - o_dat holds its last value when o_dat_vld = 0.
- **DONE (1 cycle):** o_done = 1, coinciding with the o_dat_vld of the final beat; then go to IDLE.
- **Group bubble:** between groups o_npe_rdy drops for at least 2 cycles (FETCH + WAIT). The NPE must hold vld/data while rdy = 0.
- **Abort:**
  - i_calculate_end in any state forces IDLE on the next cycle and clears p and g.
  - A beat transferred in the same cycle is discarded: o_dat_vld = 0 next cycle and no o_done.
  - An abort has priority over a simultaneous i_calc_en.
  - i_calc_en in IDLE with i_calculate_end low starts normally.
- **Busy:** i_calc_en while o_busy is high has no effect.
- **Async reset mid-run:** immediately returns every output to its reset value and drops any in-flight result.

Test Plan:
- **Basic run, 1-cycle RAM:** LANES=32, DW=16, start=0x10, part_num=2, layers=3, all lanes of each beat = 100, bias word for group g = 10*g with g in 0..2. Required: reads at 0x10, 0x11, 0x12; 6 outputs 100, 100, 110, 110, 120, 120; o_done coincides with the 6th o_dat_vld.
- **Saturation:** lane 0 = 0x7FF0 + bias 0x0020, lane 1 = 0x8005 + bias 0xFFF0. With sat_en=1 expect 0x7FFF and 0x8000; with sat_en=0 expect 0x8010 and 0x7FF5.
- **ReLU:** npe = -50, bias = 20, relu_en=1 gives 0; relu_en=0 gives -30 (0xFFE2). Positive lanes are unchanged in both cases.
- **Handshake:**
  - Hold i_npe_dat_vld high continuously with RAM latency 3; rdy is low in FETCH/WAIT and no beat may be lost or duplicated.
  - NPE vld toggled randomly; output count equals part_num*layers.
- **Abort and wrap:**
  - start=0xFE, layers=4: addresses go 0xFE, 0xFF, 0x00, 0x01.
  - Assert i_calculate_end during group 2 together with a beat: that beat produces no output, no o_done, o_busy = 0 next cycle.
  - A fresh i_calc_en then completes normally.
- **Zero config and async reset:** part_num=0 and layers=0 give exactly 1 read and 1 output. Asserting i_rst_n low mid-RUN clears all outputs the same cycle.
